// File: rtl/k_low_pass_filter_mc_if.sv
// Sample-in / result-out bus of the multi-channel low-pass filter.
// The master drives samples and receives filtered results.
interface k_low_pass_filter_mc_if #(
    parameter int DW = 16,
    parameter int CH = 8
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    logic                 in_valid;
    logic [CW-1:0]        in_ch;
    logic signed [DW-1:0] in_data;
    logic                 out_valid;
    logic [CW-1:0]        out_ch;
    logic signed [DW-1:0] out_data;

    modport master (
        output in_valid, in_ch, in_data,
        input  out_valid, out_ch, out_data
    );

    modport slave (
        input  in_valid, in_ch, in_data,
        output out_valid, out_ch, out_data
    );
endinterface

// File: rtl/k_low_pass_filter_mc.sv
// Time-multiplexed first-order IIR low-pass filter, one datapath for CH
// channels with per-channel shift factor, bypass, clear and saturation.
module k_low_pass_filter_mc #(
    parameter int DW        = 16,
    parameter int FRAC      = 32,
    parameter int CH        = 8,
    parameter int K_DEFAULT = 26,
    localparam int CW       = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    k_low_pass_filter_mc_if.slave bus,
    input  logic                 cfg_we,
    input  logic [CW-1:0]        cfg_ch,
    input  logic [4:0]           cfg_k,
    input  logic                 cfg_bypass,
    input  logic [CH-1:0]        ch_clear,
    output logic                 err
);

    localparam int AW = DW + FRAC + 1;
    localparam logic [CW:0] CH_LIM = (CW+1)'(CH);
    localparam logic signed [DW-1:0] OUT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] OUT_MIN = {1'b1, {(DW-1){1'b0}}};

    logic signed [DW-1:0] x_prev [CH];
    logic signed [AW-1:0] y_acc  [CH];
    logic [4:0]           k_r    [CH];
    logic                 byp_r  [CH];

    logic                 s1_valid;
    logic [CW-1:0]        s1_ch;
    logic signed [DW-1:0] s1_x;

    logic                 accept;
    logic                 in_ok;
    logic                 cfg_fire;
    logic                 cfg_ok;

    logic signed [AW-1:0] x_ext;
    logic signed [AW-1:0] xp_ext;
    logic signed [AW-1:0] s_sum;
    logic signed [AW-1:0] y_cur;
    logic signed [AW-1:0] y_new;
    logic [4:0]           k_cur;
    logic                 byp_cur;
    logic signed [DW-1:0] y_sat;
    logic signed [DW-1:0] s2_out;

    assign accept   = enable && bus.in_valid;
    assign in_ok    = ({1'b0, bus.in_ch} < CH_LIM);
    assign cfg_fire = enable && cfg_we;
    assign cfg_ok   = (cfg_k >= 5'd2) && ({1'b0, cfg_ch} < CH_LIM);

    // Stage 1: capture the sample; bad channel indices never enter the pipe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_x     <= '0;
        end else begin
            s1_valid <= accept && in_ok;
            if (accept && in_ok) begin
                s1_ch <= bus.in_ch;
                s1_x  <= bus.in_data;
            end
        end
    end

    // Stage 2 datapath: sum of current and previous sample, leaky update.
    always_comb begin
        y_cur   = y_acc[s1_ch];
        k_cur   = k_r[s1_ch];
        byp_cur = byp_r[s1_ch];
        x_ext   = {s1_x[DW-1], s1_x, {FRAC{1'b0}}};
        xp_ext  = {x_prev[s1_ch][DW-1], x_prev[s1_ch], {FRAC{1'b0}}};
        s_sum   = x_ext + xp_ext;
        y_new   = y_cur + (s_sum >>> k_cur) - (y_cur >>> (k_cur - 5'd1));
    end

    always_comb begin
        y_sat = y_new[DW+FRAC-1:FRAC];
        if (y_new[AW-1] != y_new[AW-2]) begin
            y_sat = y_new[AW-1] ? OUT_MIN : OUT_MAX;
        end
        s2_out = byp_cur ? s1_x : y_sat;
    end

    // Per-channel state; a clear on the same edge as a write takes priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                x_prev[c] <= '0;
                y_acc[c]  <= '0;
                k_r[c]    <= 5'(K_DEFAULT);
                byp_r[c]  <= 1'b0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (cfg_fire && cfg_ok && cfg_ch == CW'(c)) begin
                    k_r[c]   <= cfg_k;
                    byp_r[c] <= cfg_bypass;
                end
                if (enable && ch_clear[c]) begin
                    x_prev[c] <= '0;
                    y_acc[c]  <= '0;
                end else if (s1_valid && s1_ch == CW'(c)) begin
                    x_prev[c] <= s1_x;
                    y_acc[c]  <= y_new;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_ch    <= '0;
            bus.out_data  <= '0;
            err           <= 1'b0;
        end else begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.out_ch   <= s1_ch;
                bus.out_data <= s2_out;
            end
            err <= (accept && !in_ok) || (cfg_fire && !cfg_ok);
        end
    end

endmodule

// File: tb/tb_k_low_pass_filter_mc.sv
// Randomized scoreboard bench for k_low_pass_filter_mc against a
// cycle-level arithmetic reference model.
module tb_k_low_pass_filter_mc;

    localparam int DW   = 16;
    localparam int FRAC = 32;
    localparam int CH   = 6;
    localparam int KD   = 26;
    localparam int CW   = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          cfg_we = 1'b0;
    logic [CW-1:0] cfg_ch = '0;
    logic [4:0]    cfg_k = '0;
    logic          cfg_bypass = 1'b0;
    logic [CH-1:0] ch_clear = '0;
    logic          err;

    k_low_pass_filter_mc_if #(.DW(DW), .CH(CH)) bus ();

    k_low_pass_filter_mc #(
        .DW(DW), .FRAC(FRAC), .CH(CH), .K_DEFAULT(KD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .bus(bus.slave),
        .cfg_we(cfg_we),
        .cfg_ch(cfg_ch),
        .cfg_k(cfg_k),
        .cfg_bypass(cfg_bypass),
        .ch_clear(ch_clear),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int data;
        int cyc;
    } exp_t;

    exp_t oq[$];
    bit   eq[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc++;

    // Reference model state
    longint m_y [CH];
    int     m_xp[CH];
    int     m_k [CH];
    bit     m_b [CH];
    bit     pv;
    int     pch;
    int     px;

    task automatic chk(string nm, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic longint fdiv(longint a, int sh);
        longint d;
        longint q;
        d = longint'(1) << sh;
        q = a / d;
        if (a < 0 && (a % d) != 0) q = q - 1;
        return q;
    endfunction

    task automatic m_reset();
        for (int c = 0; c < CH; c++) begin
            m_y[c]  = 0;
            m_xp[c] = 0;
            m_k[c]  = KD;
            m_b[c]  = 1'b0;
        end
        pv = 1'b0;
    endtask

    // Sample pending from the previous cycle is filtered on the coming edge.
    task automatic m_stage2();
        longint s;
        longint yn;
        longint t;
        int     o;
        exp_t   e;
        if (pv) begin
            s  = (longint'(px) + longint'(m_xp[pch])) * (longint'(1) << FRAC);
            yn = m_y[pch] + fdiv(s, m_k[pch]) - fdiv(m_y[pch], m_k[pch] - 1);
            if (m_b[pch]) begin
                o = px;
            end else begin
                t = fdiv(yn, FRAC);
                if (t > 32767) t = 32767;
                if (t < -32768) t = -32768;
                o = int'(t);
            end
            e.ch = pch;
            e.data = o;
            e.cyc = cyc + 1;
            oq.push_back(e);
            m_y[pch]  = yn;
            m_xp[pch] = px;
            pv = 1'b0;
        end
    endtask

    task automatic step(bit en, bit iv, int ich, int idat, bit we, int cch,
                        int ck, bit cb, logic [CH-1:0] clr);
        bit e;
        @(negedge clk);
        enable       = en;
        bus.in_valid = iv;
        bus.in_ch    = ich[CW-1:0];
        bus.in_data  = idat[DW-1:0];
        cfg_we       = we;
        cfg_ch       = cch[CW-1:0];
        cfg_k        = ck[4:0];
        cfg_bypass   = cb;
        ch_clear     = clr;
        m_stage2();
        e = 1'b0;
        if (en) begin
            if (we) begin
                if (ck >= 2 && ck <= 31 && cch < CH) begin
                    m_k[cch] = ck;
                    m_b[cch] = cb;
                end else begin
                    e = 1'b1;
                end
            end
            for (int c = 0; c < CH; c++) begin
                if (clr[c]) begin
                    m_y[c]  = 0;
                    m_xp[c] = 0;
                end
            end
            if (iv) begin
                if (ich < CH) begin
                    pv  = 1'b1;
                    pch = ich;
                    px  = idat;
                end else begin
                    e = 1'b1;
                end
            end
        end
        eq.push_back(e);
    endtask

    task automatic samp(int ch, int x);
        step(1'b1, 1'b1, ch, x, 1'b0, 0, 0, 1'b0, '0);
    endtask

    task automatic cfg(int ch, int k, bit b);
        step(1'b1, 1'b0, 0, 0, 1'b1, ch, k, b, '0);
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        enable       = 1'b0;
        bus.in_valid = 1'b0;
        cfg_we       = 1'b0;
        ch_clear     = '0;
        oq.delete();
        eq.delete();
        m_reset();
        #1;
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_out_ch", longint'(bus.out_ch), 0);
        chk("rst_out_data", longint'(bus.out_data), 0);
        chk("rst_err", longint'(err), 0);
        eq.push_back(1'b0);
        repeat (2) begin
            @(negedge clk);
            eq.push_back(1'b0);
        end
        @(negedge clk);
        reset = 1'b0;
        eq.push_back(1'b0);
    endtask

    // Monitor: err checked every edge, results popped as they appear.
    initial begin : monitor
        exp_t x;
        bit   e;
        forever begin
            @(posedge clk);
            #1;
            if (eq.size() > 0) begin
                e = eq.pop_front();
                chk("err", longint'(err), longint'(e));
            end
            if (bus.out_valid) begin
                if (oq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: got ch %0d data %0d expected no output",
                             bus.out_ch, bus.out_data);
                end else begin
                    x = oq.pop_front();
                    chk("out_ch", longint'(bus.out_ch), x.ch);
                    chk("out_data", longint'(bus.out_data), x.data);
                    chk("out_cycle", cyc, x.cyc);
                end
            end else if (oq.size() > 0 && oq[0].cyc <= cyc) begin
                x = oq.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missing_out: got none expected ch %0d data %0d at cycle %0d",
                         x.ch, x.data, x.cyc);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        bit            r_en;
        bit            r_iv;
        bit            r_we;
        bit            r_cb;
        int            r_ch;
        int            r_dat;
        int            r_cch;
        int            r_k;
        logic [CH-1:0] r_clr;

        bus.in_valid = 1'b0;
        bus.in_ch    = '0;
        bus.in_data  = '0;
        do_reset();

        cfg(0, 2, 1'b0);
        cfg(1, 2, 1'b0);
        repeat (10) samp(0, 1000);

        step(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 6'b000011);
        for (int i = 0; i < 12; i++) samp(i % 2, (i % 2) ? -1000 : 1000);

        cfg(2, 2, 1'b0);
        repeat (40) samp(2, 32767);
        step(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 6'b000100);
        repeat (40) samp(2, -32768);

        cfg(3, 2, 1'b1);
        samp(3, 123);
        idle(3);
        cfg(3, 2, 1'b0);
        repeat (4) samp(3, 123);

        cfg(0, 1, 1'b0);
        cfg(CH, 2, 1'b0);
        samp(CH, 5);
        samp(7, 5);
        samp(0, 1000);
        idle(2);

        samp(0, 500);
        step(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 6'b000001);
        samp(0, 1000);
        idle(2);

        samp(1, 2000);
        step(1'b1, 1'b1, 1, 2000, 1'b1, 1, 5, 1'b0, '0);
        samp(1, 2000);
        idle(2);

        samp(0, 300);
        step(1'b0, 1'b1, 0, 500, 1'b1, 0, 9, 1'b1, 6'b111111);
        idle(2);
        samp(0, 300);
        idle(2);

        for (int i = 0; i < 800; i++) begin
            if (i == 400) begin
                do_reset();
                repeat (3) samp(0, 32767);
            end
            r_en  = ($urandom_range(0, 19) != 0);
            r_iv  = ($urandom_range(0, 3) != 0);
            r_ch  = ($urandom_range(0, 15) < 14) ? $urandom_range(0, CH - 1)
                                                 : $urandom_range(CH, 7);
            case ($urandom_range(0, 5))
                0:       r_dat = 32767;
                1:       r_dat = -32768;
                default: r_dat = int'($urandom_range(0, 65535)) - 32768;
            endcase
            r_we  = ($urandom_range(0, 9) == 0);
            r_cch = $urandom_range(0, 7);
            r_k   = $urandom_range(0, 31);
            r_cb  = ($urandom_range(0, 3) == 0);
            r_clr = ($urandom_range(0, 19) == 0) ? CH'($urandom) : '0;
            step(r_en, r_iv, r_ch, r_dat, r_we, r_cch, r_k, r_cb, r_clr);
        end

        idle(4);
        chk("queue_drained", oq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/k_low_pass_filter_mc.md
# k_low_pass_filter_mc

Time-multiplexed, multi-channel first-order IIR low-pass filter for the self-trigger filtering chain. One arithmetic datapath serves up to CH channels; per-channel state and shift factor live in internal register arrays. It adds per-channel runtime k, per-channel bypass and clear, arithmetic-correct shifting and output saturation. It sits between the channel sample mux and the self-trigger comparators.

## Interface
- DW, 16, sample and output width (signed)
- FRAC, 32, fractional bits of the accumulator
- CH, 8, number of channels (≥1); CW = max(1, clog2(CH))
- K_DEFAULT, 26, shift factor loaded into every channel at reset (2..31)
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  global enable; when low, in_valid and cfg_we are ignored and state holds
- in_valid  in  1  sample strobe
- in_ch  in  CW  channel index of sample
- in_data  in  DW  signed sample
- cfg_we  in  1  config write strobe
- cfg_ch  in  CW  channel to configure
- cfg_k  in  5  new shift factor
- cfg_bypass  in  1  new bypass bit
- ch_clear  in  CH  per-channel synchronous state clear (bitmask)
- out_valid  out  1  result strobe
- out_ch  out  CW  channel of result
- out_data  out  DW  signed filtered sample
- err  out  1  one-cycle pulse: bad channel index or illegal cfg_k

## Operation
- Accumulator width AW = DW+FRAC+1 (signed); per-channel state: x_prev[DW], y_acc[AW], k[5], bypass[1].
- Stage 1 (edge after accepted in_valid): register in_ch, in_data.
- Stage 2 (next edge), for channel c, x = registered sample, using sign-extended AW arithmetic:
  - s = ({x, FRAC zeros}) + ({x_prev[c], FRAC zeros}), computed in AW bits (no wrap).
  - y_new = y_acc[c] + (s >>> k[c]) − (y_acc[c] >>> (k[c]−1)); all shifts arithmetic.
  - Write x_prev[c] = x, y_acc[c] = y_new.
  - out_data = y_new[DW+FRAC−1:FRAC], saturated to +2^(DW−1)−1 / −2^(DW−1) when y_new[AW−1] ≠ y_new[AW−2].
  - If bypass[c]: out_data = x; x_prev/y_acc still updated (seamless exit from bypass).
- Steady-state DC gain is exactly 1 (y_acc → x·2^FRAC).
- in_ch ≥ CH: sample dropped in stage 1, no out_valid, err pulses with the stage-1 register edge.
- cfg_we with cfg_k outside 2..31 or cfg_ch ≥ CH: write discarded, err pulses. A legal write updates k and bypass on the next edge; it does not touch x_prev/y_acc.
- ch_clear[c] high on an edge: x_prev[c], y_acc[c] ← 0; k and bypass kept.

## Timing
- Reset values: out_valid 0, out_ch 0, out_data 0, err 0; all x_prev/y_acc 0; all k = K_DEFAULT; all bypass 0; pipeline registers 0.
- Latency: in_valid at edge N → out_valid high for one cycle after edge N+2. Throughput 1 sample/clock, any channel order.
- Back-to-back same channel: stage 2 of sample n writes state on the edge where sample n+1 enters stage 2, so n+1 uses n's result. No stall, no forwarding error.
- Simultaneous cfg write and stage-2 sample on the same channel: sample uses old k/bypass; new values apply to the next sample.
- Simultaneous ch_clear[c] and stage-2 write to c: the output is computed and emitted from the pre-clear state; clear wins the state write (state = 0 afterwards).
- enable low: the stage-1 capture is suppressed; a sample already in stage 1 completes; config and clear are ignored.
- reset asserted mid-stream: in-flight samples are lost, out_valid deasserts immediately (async), all state reverts to reset values.

## Test plan
- k=2 on ch0, x=1000 steady from zero state → out_data 250, 625, 812, then converges to 1000 (never exceeds it).
- Interleaved ch0=+1000 / ch1=−1000, k=2 → ch0 250, 625, 812…; ch1 −250, −625, −813… (arithmetic floor); no cross-channel leakage.
- x=+32767 held, k=2 → output settles at 32767 with no wrap. x=−32768 held → settles at −32768.
- Set bypass on ch3, send 123 → out 123 after 2 cycles. Clear bypass → next output continues filtering from x_prev=123.
- cfg_k=1 or cfg_ch=CH, and in_ch=CH → err pulses; k unchanged; no out_valid.
- ch_clear on ch0 in the same cycle as a ch0 stage-2 sample → that output is emitted normally. Next sample x=1000 at k=2 → 250 (fresh state). Reset mid-stream → all outputs 0 and k back to K_DEFAULT.
